// File: rtl/alu_issue_queue.sv
// In-order operand FIFO feeding an external combinational ALU, with a registered
// result stage. Both sides use valid/ready handshakes.
module alu_issue_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_A,
  input  logic [DATA_WIDTH-1:0]      in_B,
  input  logic [2:0]                 in_ALUop,
  output logic [DATA_WIDTH-1:0]      alu_A,
  output logic [DATA_WIDTH-1:0]      alu_B,
  output logic [2:0]                 alu_ALUop,
  input  logic [DATA_WIDTH-1:0]      alu_Result,
  input  logic                       alu_Overflow,
  input  logic                       alu_CarryOut,
  input  logic                       alu_Zero,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_Result,
  output logic                       out_Overflow,
  output logic                       out_CarryOut,
  output logic                       out_Zero,
  output logic                       out_err,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] memA [DEPTH];
  logic [DATA_WIDTH-1:0] memB [DEPTH];
  logic [2:0]            memOp [DEPTH];

  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          notEmpty;
  logic          headIllegal;

  assign notEmpty  = (count != '0);
  assign in_ready  = (count < CW'(DEPTH));
  assign push      = in_valid & in_ready;
  // The FIFO only drains into the output stage when that stage is free or being emptied.
  assign pop       = notEmpty & (~out_valid | out_ready);
  assign occupancy = count;

  assign alu_A     = memA[rdPtr];
  assign alu_B     = memB[rdPtr];
  assign alu_ALUop = notEmpty ? memOp[rdPtr] : 3'b000;

  assign headIllegal = (alu_ALUop == 3'b011) || (alu_ALUop == 3'b100) ||
                       (alu_ALUop == 3'b101);

  // Storage needs no reset: entries are only read once the count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      memA[wrPtr]  <= in_A;
      memB[wrPtr]  <= in_B;
      memOp[wrPtr] <= in_ALUop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop)  rdPtr <= rdPtr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_Result   <= '0;
      out_Overflow <= 1'b0;
      out_CarryOut <= 1'b0;
      out_Zero     <= 1'b0;
      out_err      <= 1'b0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_err   <= headIllegal;
      if (headIllegal) begin
        out_Result   <= '0;
        out_Overflow <= 1'b0;
        out_CarryOut <= 1'b0;
        out_Zero     <= 1'b0;
      end else begin
        out_Result   <= alu_Result;
        out_Overflow <= alu_Overflow;
        out_CarryOut <= alu_CarryOut;
        out_Zero     <= alu_Zero;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: behavioural ALU on the alu_* side, scoreboard of
// expected results filled on accept and drained by an output monitor.
module tb_alu_issue_queue;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_A = '0;
  logic [DW-1:0] in_B = '0;
  logic [2:0]    in_ALUop = '0;
  logic [DW-1:0] alu_A, alu_B;
  logic [2:0]    alu_ALUop;
  logic [DW-1:0] alu_Result;
  logic          alu_Overflow, alu_CarryOut, alu_Zero;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_Result;
  logic          out_Overflow, out_CarryOut, out_Zero, out_err;
  logic [$clog2(DEPTH):0] occupancy;

  typedef struct packed {
    logic [31:0] res;
    logic        ov;
    logic        co;
    logic        z;
    logic        err;
  } resp_t;

  resp_t sb[$];
  resp_t aluOut;
  resp_t monExp;
  resp_t monAct;
  int    errors = 0;
  int    checks = 0;
  int    accepted = 0;

  always #5 clk = ~clk;

  alu_issue_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_A(in_A), .in_B(in_B), .in_ALUop(in_ALUop),
    .alu_A(alu_A), .alu_B(alu_B), .alu_ALUop(alu_ALUop),
    .alu_Result(alu_Result), .alu_Overflow(alu_Overflow),
    .alu_CarryOut(alu_CarryOut), .alu_Zero(alu_Zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_Result(out_Result), .out_Overflow(out_Overflow),
    .out_CarryOut(out_CarryOut), .out_Zero(out_Zero),
    .out_err(out_err), .occupancy(occupancy)
  );

  // Reference ALU; illegal codes produce deliberate garbage so forcing to zero is visible.
  function automatic resp_t aluModel(input logic [31:0] a, input logic [31:0] b,
                                     input logic [2:0] op);
    resp_t r;
    logic [32:0] s;
    r = '0;
    case (op)
      3'b000: r.res = a & b;
      3'b001: r.res = a | b;
      3'b010: begin
        s = {1'b0, a} + {1'b0, b};
        r.res = s[31:0];
        r.co = s[32];
        r.ov = (a[31] == b[31]) && (r.res[31] != a[31]);
      end
      3'b110: begin
        r.res = a - b;
        r.co = (a < b);
        r.ov = (a[31] != b[31]) && (r.res[31] != a[31]);
      end
      3'b111: r.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: begin
        r.res = a ^ b ^ 32'hDEAD_BEEF;
        r.ov = 1'b1;
        r.co = 1'b1;
        return r;
      end
    endcase
    r.z = (r.res == 32'd0);
    return r;
  endfunction

  function automatic resp_t expected(input logic [31:0] a, input logic [31:0] b,
                                     input logic [2:0] op);
    resp_t r;
    if (op == 3'b011 || op == 3'b100 || op == 3'b101) begin
      r = '0;
      r.err = 1'b1;
    end else begin
      r = aluModel(a, b, op);
    end
    return r;
  endfunction

  assign aluOut       = aluModel(alu_A, alu_B, alu_ALUop);
  assign alu_Result   = aluOut.res;
  assign alu_Overflow = aluOut.ov;
  assign alu_CarryOut = aluOut.co;
  assign alu_Zero     = aluOut.z;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare on every output handshake, then record any new accept.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 64'(out_valid), 64'(0));
        end else begin
          monExp = sb.pop_front();
          monAct = {out_Result, out_Overflow, out_CarryOut, out_Zero, out_err};
          checks++;
          if (monAct !== monExp) begin
            errors++;
            $display("FAIL result: got res=%h ov=%b co=%b z=%b err=%b expected res=%h ov=%b co=%b z=%b err=%b",
                     monAct.res, monAct.ov, monAct.co, monAct.z, monAct.err,
                     monExp.res, monExp.ov, monExp.co, monExp.z, monExp.err);
          end else begin
            $display("ok   result res=%h ov=%b co=%b z=%b err=%b",
                     monAct.res, monAct.ov, monAct.co, monAct.z, monAct.err);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(expected(in_A, in_B, in_ALUop));
        accepted++;
        $display("push A=%h B=%h op=%b", in_A, in_B, in_ALUop);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendOne(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    bit acc;
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_A = a;
    in_B = b;
    in_ALUop = op;
    for (int t = 0; t < 50 && !done; t++) begin
      acc = in_ready;
      tick();
      if (acc) done = 1'b1;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 64'(done), 64'(1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid || occupancy != 0) && n < 60) begin
      tick();
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'(0));
  endtask

  function automatic logic [31:0] randOperand();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'h0000_0000;
      1: v = 32'h7FFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = 32'hFFFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int n;
    int acc0;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_occupancy", 64'(occupancy), 64'(0));
    check("rst_out_result", 64'(out_Result), 64'(0));
    check("rst_out_err", 64'(out_err), 64'(0));
    check("rst_alu_op_empty", 64'(alu_ALUop), 64'(0));
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 64'(in_ready), 64'(1));

    // ADD overflow with latency check
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_A = 32'h7FFF_FFFF;
    in_B = 32'h0000_0001;
    in_ALUop = 3'b010;
    tick();
    in_valid = 1'b0;
    check("lat_edgeN_valid", 64'(out_valid), 64'(0));
    check("lat_edgeN_occ", 64'(occupancy), 64'(1));
    tick();
    check("lat_edgeN1_valid", 64'(out_valid), 64'(1));
    check("add_result", 64'(out_Result), 64'(32'h8000_0000));
    check("add_flags", 64'({out_Overflow, out_CarryOut, out_Zero}), 64'(3'b100));
    drain();

    // SUB to zero then SLT with most-negative A
    sendOne(32'd5, 32'd5, 3'b110);
    sendOne(32'h8000_0000, 32'd1, 3'b111);
    drain();

    // Illegal op followed by a legal one
    sendOne(32'd3, 32'd4, 3'b011);
    tick();
    check("illegal_err", 64'({out_valid, out_err}), 64'(2'b11));
    check("illegal_zeroed", 64'({out_Result, out_Overflow, out_CarryOut, out_Zero}), 64'(0));
    sendOne(32'd3, 32'd4, 3'b010);
    tick();
    check("legal_err", 64'({out_valid, out_err}), 64'(2'b10));
    drain();

    // Backpressure fill: six attempts, five accepted
    out_ready = 1'b0;
    acc0 = accepted;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_A = randOperand();
      in_B = randOperand();
      in_ALUop = 3'b001 << (i % 2);
      tick();
    end
    in_valid = 1'b0;
    check("bp_accepted", 64'(accepted - acc0), 64'(5));
    check("bp_in_ready", 64'(in_ready), 64'(0));
    check("bp_occupancy", 64'(occupancy), 64'(DEPTH));
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    check("bp_drain_cycles", 64'(n), 64'(5));
    drain();

    // Steady push+pop at occupancy 2 across pointer wrap
    out_ready = 1'b0;
    sendOne(32'd10, 32'd20, 3'b010);
    sendOne(32'd30, 32'd7, 3'b110);
    sendOne(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b000);
    check("sim_occ_start", 64'(occupancy), 64'(2));
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 2 * DEPTH + 2; i++) begin
      in_A = $urandom;
      in_B = $urandom;
      in_ALUop = (i % 2 == 0) ? 3'b010 : 3'b111;
      tick();
      check("sim_occ_steady", 64'(occupancy), 64'(2));
    end
    in_valid = 1'b0;
    drain();

    // Asynchronous reset with results in flight
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) sendOne($urandom, $urandom, 3'b010);
    check("mid_occ", 64'(occupancy), 64'(3));
    check("mid_valid", 64'(out_valid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'(0));
    check("async_rst_occ", 64'(occupancy), 64'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", 64'(in_ready), 64'(1));
    check("post_rst_valid", 64'(out_valid), 64'(0));

    // Randomised traffic with all op codes
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_A = randOperand();
      in_B = randOperand();
      in_ALUop = 3'($urandom_range(0, 7));
      tick();
    end
    in_valid = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
